// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REGW      = 5;
  localparam int unsigned MDU_ITERS = 32;
  localparam int unsigned CNTW      = $clog2(MDU_ITERS);

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 iterative RV32M multiply/divide feeding the register file write port.
// Multiply and divide share one 64-bit accumulator; FIX spends one cycle on sign fixup and one on result select.
module mdu_iter
  import mdu_pkg::*;
(
  input  logic             MDU_clk,
  input  logic             MDU_rst_n,
  input  logic             MDU_start,
  input  logic [2:0]       MDU_op,
  input  logic [XLEN-1:0]  MDU_rs1,
  input  logic [XLEN-1:0]  MDU_rs2,
  input  logic [REGW-1:0]  MDU_rd_in,
  input  logic             MDU_kill,
  output logic             MDU_busy,
  output logic             MDU_done,
  output logic [XLEN-1:0]  MDU_result,
  output logic [REGW-1:0]  MDU_rd
);

  mdu_state_t          r_state, w_state_nxt;
  mdu_op_t             r_op;
  logic [CNTW-1:0]     r_cnt;
  logic                r_fix_ph;
  logic                r_sign_a, r_sign_b;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_busy, r_done;
  logic [XLEN-1:0]     r_result;
  logic [REGW-1:0]     r_rd;

  logic                w_accept, w_in_div, w_in_rem, w_sa, w_sb;
  logic                w_div0, w_ovf, w_special;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res;
  logic [XLEN-1:0]     w_mul_add, w_quo, w_rem, w_rem_nxt, w_sel;
  logic [XLEN:0]       w_mul_sum, w_div_shift;
  logic [XLEN+1:0]     w_div_diff;
  logic                w_qbit;
  logic [2*XLEN-1:0]   w_step, w_fixed;

  // Request decode: operand signedness, magnitudes and the early-out cases.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && MDU_start && !MDU_kill;
    w_in_div  = MDU_op[2];
    w_in_rem  = MDU_op[2] && MDU_op[1];
    w_sa      = MDU_rs1[XLEN-1] && (MDU_op == OP_MULH || MDU_op == OP_MULHSU ||
                                    MDU_op == OP_DIV  || MDU_op == OP_REM);
    w_sb      = MDU_rs2[XLEN-1] && (MDU_op == OP_MULH || MDU_op == OP_DIV ||
                                    MDU_op == OP_REM);
    w_mag_a   = w_sa ? -MDU_rs1 : MDU_rs1;
    w_mag_b   = w_sb ? -MDU_rs2 : MDU_rs2;
    w_div0    = w_in_div && (MDU_rs2 == '0);
    w_ovf     = (MDU_op == OP_DIV || MDU_op == OP_REM) &&
                (MDU_rs1 == INT_MIN) && (MDU_rs2 == ALL_ONES);
    w_special = w_div0 || w_ovf;
    if (w_div0) w_special_res = w_in_rem ? MDU_rs1 : ALL_ONES;
    else        w_special_res = w_in_rem ? '0 : INT_MIN;
  end

  // One iteration: shift-add multiply or restoring divide on the shared accumulator.
  always_comb begin
    w_mul_add   = r_acc[0] ? r_opnd : '0;
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_mul_add};
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    w_qbit      = ~w_div_diff[XLEN+1];
    w_rem_nxt   = w_qbit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_step      = r_op[2] ? {w_rem_nxt, r_acc[XLEN-2:0], w_qbit}
                          : {w_mul_sum, r_acc[XLEN-1:1]};
    w_quo       = r_acc[XLEN-1:0];
    w_rem       = r_acc[2*XLEN-1:XLEN];
    if (r_op[2])
      w_fixed = {(r_sign_a ? -w_rem : w_rem), ((r_sign_a ^ r_sign_b) ? -w_quo : w_quo)};
    else
      w_fixed = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    case (r_op)
      OP_MUL, OP_DIV, OP_DIVU: w_sel = r_acc[XLEN-1:0];
      default:                 w_sel = r_acc[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic; kill forces IDLE from any busy state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   if (r_fix_ph) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (MDU_kill && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
    if (!MDU_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
    if (!MDU_rst_n) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_fix_ph <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op     <= mdu_op_t'(MDU_op);
          r_rd     <= MDU_rd_in;
          r_sign_a <= w_sa;
          r_sign_b <= w_sb;
          r_opnd   <= w_in_div ? w_mag_b : w_mag_a;
          r_acc    <= {{XLEN{1'b0}}, (w_in_div ? w_mag_a : w_mag_b)};
          r_cnt    <= CNTW'(MDU_ITERS - 1);
          r_fix_ph <= 1'b0;
          if (w_special) r_result <= w_special_res;
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CNTW'(1);
        end
        S_FIX: begin
          if (!r_fix_ph) begin
            r_acc    <= w_fixed;
            r_fix_ph <= 1'b1;
          end else if (w_state_nxt == S_DONE) begin
            r_result <= w_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign MDU_busy   = r_busy;
  assign MDU_done   = r_done;
  assign MDU_result = r_result;
  assign MDU_rd     = r_rd;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, arithmetic, special cases, kill and reset.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter dut (
    .MDU_clk(clk), .MDU_rst_n(rst_n), .MDU_start(start), .MDU_op(op),
    .MDU_rs1(rs1), .MDU_rs2(rs2), .MDU_rd_in(rd_in), .MDU_kill(kill),
    .MDU_busy(busy), .MDU_done(done), .MDU_result(result), .MDU_rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns just after the accept edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
    op = o; rs1 = a; rs2 = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(o, a, b, r);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, 32'(rd), 32'(r));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, n;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 34);
    do_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd12, 32'h4000_0000, 34);
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, 34);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, 34);
    do_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd15, 32'hFFFF_FFFD, 34);
    do_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd16, 32'hFFFF_FFFF, 34);
    do_op("divu",   3'd5, 32'd100,        32'd7,         5'd17, 32'd14,        34);
    do_op("remu",   3'd7, 32'd100,        32'd7,         5'd0,  32'd2,         34);
    do_op("div0",   3'd4, 32'd5,          32'd0,         5'd18, 32'hFFFF_FFFF, 0);
    do_op("rem0",   3'd6, 32'd5,          32'd0,         5'd19, 32'd5,         0);
    do_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 0);
    do_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'd0,         0);

    // Second start at cycle 5 of a MUL must be dropped.
    start_op(3'd0, 32'd5, 32'd6, 5'd3);
    repeat (4) begin @(posedge clk); #1; end
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_lat", 32'(lat + 5), 32'd34);
    chk("busy_start_res", result, 32'd30);
    chk("busy_start_rd", 32'(rd), 32'd3);
    count_dones(45, n);
    chk("busy_start_ndone", 32'(n), 32'd0);

    // Kill at cycle 10: abort without a done pulse or result update.
    start_op(3'd5, 32'd100, 32'd7, 5'd4);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_result", result, 32'd30);
    count_dones(40, n);
    chk("kill_ndone", 32'(n), 32'd0);

    // Kill together with start in IDLE: nothing starts.
    op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd6; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", 32'(busy), 32'd0);
    count_dones(40, n);
    chk("killstart_ndone", 32'(n), 32'd0);
    chk("killstart_result", result, 32'd30);

    // Asynchronous reset at cycle 20 of a DIV.
    start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst_mul", 3'd0, 32'd3, 32'd4, 5'd2, 32'd12, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
